// File: rtl/game_pkg.sv
// game_pkg: shared game flow state encoding and widths for the sequencer, sprite and HUD blocks
package game_pkg;
  localparam int STATE_W = 3;
  localparam int ENEMY_W = 4;
  typedef enum logic [STATE_W-1:0] {
    TITLE     = 3'd0,
    READY     = 3'd1,
    PLAY      = 3'd2,
    DYING     = 3'd3,
    CLEAR     = 3'd4,
    GAME_OVER = 3'd5
  } game_state_t;
endpackage

// File: rtl/game_flow_ctrl_frame_timer.sv
// frame_timer: frame tick counter (Clk, Reset, clr, tick, n in; done out) flagging the Nth tick of a phase
module frame_timer #(
  parameter int MAX_N = 120
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         clr,
  input  logic                         tick,
  input  logic [$clog2(MAX_N+1)-1:0]   n,
  output logic                         done
);
  localparam int W = $clog2(MAX_N + 1);
  logic [W-1:0] cnt;
  always_comb done = tick & (cnt == n - W'(1));
  always_ff @(posedge Clk) begin
    if (Reset || clr) cnt <= '0;
    else if (tick) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game sequencer (Clk, Reset, frame_tick, start_key, player_hit, enemies_left in; game_state, play_en, level_load, player_respawn, lives, level out)
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int MAX_LEVEL    = 15,
  parameter int LEVEL_W      = 4,
  parameter int READY_FRAMES = 60,
  parameter int DEATH_FRAMES = 120,
  parameter int CLEAR_FRAMES = 90
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               start_key,
  input  logic               player_hit,
  input  logic [ENEMY_W-1:0] enemies_left,
  output game_state_t        game_state,
  output logic               play_en,
  output logic               level_load,
  output logic               player_respawn,
  output logic [1:0]         lives,
  output logic [LEVEL_W-1:0] level
);
  localparam int TMAX = READY_FRAMES > DEATH_FRAMES ?
                        (READY_FRAMES > CLEAR_FRAMES ? READY_FRAMES : CLEAR_FRAMES) :
                        (DEATH_FRAMES > CLEAR_FRAMES ? DEATH_FRAMES : CLEAR_FRAMES);
  localparam int CW = $clog2(TMAX + 1);
  logic start_q, start_rise, done, leave, cleared;
  logic [CW-1:0] n;
  always_comb begin
    start_rise = start_key & ~start_q;
    cleared = frame_tick & ~|enemies_left;
    n = game_state == READY ? CW'(READY_FRAMES) :
        game_state == DYING ? CW'(DEATH_FRAMES) :
        game_state == CLEAR ? CW'(CLEAR_FRAMES) : '0;
    // Any state exit restarts the timer so the next phase counts from zero.
    leave = (game_state inside {READY, DYING, CLEAR}) ? done :
            (game_state inside {TITLE, GAME_OVER})   ? start_rise :
            game_state == PLAY                       ? (player_hit | cleared) : 1'b0;
  end
  frame_timer #(.MAX_N(TMAX)) u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (leave),
    .tick  (frame_tick),
    .n     (n),
    .done  (done)
  );
  always_ff @(posedge Clk) begin
    if (Reset) begin
      game_state     <= TITLE;
      lives          <= '0;
      level          <= '0;
      start_q        <= 1'b1;
      play_en        <= 1'b0;
      level_load     <= 1'b0;
      player_respawn <= 1'b0;
    end else begin
      start_q        <= start_key;
      play_en        <= 1'b0;
      level_load     <= 1'b0;
      player_respawn <= 1'b0;
      case (game_state)
        TITLE: if (start_rise) begin
          game_state <= READY;
          lives      <= 2'(LIVES_INIT);
          level      <= LEVEL_W'(1);
          level_load <= 1'b1;
        end
        READY: begin
          play_en <= done;
          if (done) game_state <= PLAY;
        end
        PLAY: begin
          play_en <= ~(player_hit | cleared);
          if (player_hit) game_state <= DYING;
          else if (cleared) game_state <= CLEAR;
        end
        DYING: if (done) begin
          if (lives == 2'd1) begin
            game_state <= GAME_OVER;
            lives      <= '0;
          end else begin
            game_state     <= READY;
            lives          <= lives - 2'd1;
            player_respawn <= 1'b1;
          end
        end
        CLEAR: if (done) begin
          game_state <= READY;
          level      <= level == LEVEL_W'(MAX_LEVEL) ? LEVEL_W'(1) : level + LEVEL_W'(1);
          level_load <= 1'b1;
        end
        GAME_OVER: if (start_rise) game_state <= TITLE;
        default: game_state <= TITLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: randomized check of game_flow_ctrl against a countdown-based behavioural model
module tb_game_flow_ctrl;
  import game_pkg::*;
  logic Clk = 1'b0, Reset, frame_tick, start_key, player_hit;
  logic [3:0] enemies_left;
  game_state_t game_state;
  logic play_en, level_load, player_respawn;
  logic [1:0] lives;
  logic [3:0] level;
  int n_cmp = 0, n_bad = 0;

  game_state_t m_state;
  int m_lives, m_level, m_remain;
  bit m_prev_key, m_load, m_resp;

  always #5 Clk = ~Clk;

  game_flow_ctrl dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_tick     (frame_tick),
    .start_key      (start_key),
    .player_hit     (player_hit),
    .enemies_left   (enemies_left),
    .game_state     (game_state),
    .play_en        (play_en),
    .level_load     (level_load),
    .player_respawn (player_respawn),
    .lives          (lives),
    .level          (level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Phase lengths are tracked as ticks remaining; a phase ends when the count reaches zero.
  task automatic model_step();
    bit rise;
    if (Reset) begin
      m_state = TITLE; m_lives = 0; m_level = 0; m_remain = 0;
      m_prev_key = 1'b1; m_load = 1'b0; m_resp = 1'b0;
      return;
    end
    rise = start_key && !m_prev_key;
    m_prev_key = start_key;
    m_load = 1'b0;
    m_resp = 1'b0;
    case (m_state)
      TITLE: if (rise) begin
        m_state = READY; m_lives = 3; m_level = 1; m_load = 1'b1; m_remain = 60;
      end
      READY: if (frame_tick && --m_remain == 0) m_state = PLAY;
      PLAY:
        if (player_hit) begin m_state = DYING; m_remain = 120; end
        else if (frame_tick && enemies_left == 0) begin m_state = CLEAR; m_remain = 90; end
      DYING: if (frame_tick && --m_remain == 0) begin
        if (m_lives == 1) begin m_state = GAME_OVER; m_lives = 0; end
        else begin m_state = READY; m_lives--; m_resp = 1'b1; m_remain = 60; end
      end
      CLEAR: if (frame_tick && --m_remain == 0) begin
        m_state = READY; m_level = m_level % 15 + 1; m_load = 1'b1; m_remain = 60;
      end
      GAME_OVER: if (rise) m_state = TITLE;
      default: m_state = TITLE;
    endcase
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    check("state", game_state, m_state);
    check("play_en", play_en, m_state == PLAY);
    check("level_load", level_load, m_load);
    check("player_respawn", player_respawn, m_resp);
    check("lives", lives, m_lives);
    check("level", level, m_level);
  endtask

  initial begin
    Reset = 1'b1; start_key = 1'b1; frame_tick = 1'b0; player_hit = 1'b0; enemies_left = 4'd5;
    repeat (3) cycle();
    Reset = 1'b0;
    repeat (5) cycle();
    start_key = 1'b0;
    repeat (3) cycle();
    start_key = 1'b1;
    cycle();
    start_key = 1'b0;
    for (int i = 0; i < 36000; i++) begin
      frame_tick   = $urandom_range(0, 1) == 0;
      if ($urandom_range(0, 19) == 0) start_key = ~start_key;
      // Early stretch has no hits so the level counter runs through its wrap.
      player_hit   = i >= 16000 && $urandom_range(0, 59) == 0;
      enemies_left = $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom_range(1, 15));
      Reset        = $urandom_range(0, 6999) == 0;
      cycle();
    end
    Reset = 1'b0; player_hit = 1'b0; frame_tick = 1'b0;
    repeat (2) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
